// File: rtl/delay_timer_pkg.sv
// delay_timer_pkg: shared types, default parameters and width helper for the
// programmable delay timer.
package delay_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEF_DELAY_W         = 4;
  localparam int DEF_CYCLES_PER_UNIT = 1000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int presc_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/unit_prescaler.sv
// unit_prescaler: free-running 0..CYCLES_PER_UNIT-1 counter while enabled.
// tc is high on the cycle the counter sits at its last value, so the edge
// that wraps it back to zero is the unit boundary.
module unit_prescaler
  import delay_timer_pkg::*;
#(
  parameter int CYCLES_PER_UNIT = DEF_CYCLES_PER_UNIT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int            PW   = presc_width(CYCLES_PER_UNIT);
  localparam logic [PW-1:0] LAST = PW'(CYCLES_PER_UNIT - 1);

  logic [PW-1:0] cnt;

  // With one cycle per unit LAST is 0, so tc follows enable every cycle.
  assign tc = enable && (cnt == LAST);

  // Cycle counter; clear wins so every COUNT entry starts a full unit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt <= '0;
    else if (clear)  cnt <= '0;
    else if (enable) cnt <= (cnt == LAST) ? '0 : cnt + PW'(1);
  end

endmodule

// File: rtl/delay_timer_fsm.sv
// delay_timer_fsm: on a rising start_shifting, shifts DELAY_W delay bits
// (MSB first) off data, counts (delay+1) units of CYCLES_PER_UNIT cycles,
// then holds done until ack.
// Optional build macro TIMER_ABORT_EN adds an abort input that returns any
// busy state to IDLE on the sampling edge, ahead of ack and unit terminal.
module delay_timer_fsm
  import delay_timer_pkg::*;
#(
  parameter int DELAY_W         = DEF_DELAY_W,
  parameter int CYCLES_PER_UNIT = DEF_CYCLES_PER_UNIT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               data,
  input  logic               start_shifting,
  input  logic               ack,
`ifdef TIMER_ABORT_EN
  input  logic               abort,
`endif
  output logic               counting,
  output logic [DELAY_W-1:0] count,
  output logic               done
);

  localparam int BW = presc_width(DELAY_W);

  state_t             state, state_nx;
  logic               start_q;
  logic [DELAY_W-1:0] shreg;
  logic [DELAY_W-1:0] count_q;
  logic [BW-1:0]      bit_cnt;
  logic [DELAY_W:0]   shcat;
  logic               last_bit;
  logic               tc;
  logic               abort_i;

`ifdef TIMER_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // Shift register plus the incoming bit; the low DELAY_W bits are the
  // value after this edge's sample.
  assign shcat    = {shreg, data};
  assign last_bit = (bit_cnt == BW'(DELAY_W - 1));

  // Prescaler only runs in COUNT and is held at zero everywhere else.
  unit_prescaler #(
    .CYCLES_PER_UNIT(CYCLES_PER_UNIT)
  ) u_presc (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != COUNT),
    .enable (state == COUNT),
    .tc     (tc)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state: rising-edge start, DELAY_W samples, units down to 0, ack.
  always_comb begin
    state_nx = state;
    if (abort_i && state != IDLE) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (start_shifting && !start_q) state_nx = SHIFT;
        SHIFT:   if (last_bit)                   state_nx = COUNT;
        COUNT:   if (tc && count_q == '0)        state_nx = DONE;
        DONE:    if (ack)                        state_nx = IDLE;
        default:                                 state_nx = IDLE;
      endcase
    end
  end

  // Datapath: start edge history, delay shifting and unit countdown.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      count_q <= '0;
    end else begin
      start_q <= start_shifting;
      unique case (state)
        SHIFT: begin
          shreg   <= shcat[DELAY_W-1:0];
          bit_cnt <= bit_cnt + BW'(1);
          if (last_bit) count_q <= shcat[DELAY_W-1:0];
        end
        COUNT: begin
          if (tc && count_q != '0) count_q <= count_q - DELAY_W'(1);
        end
        // IDLE always precedes SHIFT by at least one edge, so the bit
        // counter is guaranteed clean even after an aborted shift.
        default: bit_cnt <= '0;
      endcase
    end
  end

  // Outputs decoded straight from the registered state.
  always_comb begin
    counting = (state == COUNT);
    count    = (state == COUNT) ? count_q : '0;
    done     = (state == DONE);
  end

endmodule

// File: tb/tb_delay_timer_fsm.sv
// tb_delay_timer_fsm: three timer instances (4, 1 and 1000 cycles per unit)
// checked every cycle against a timeline model, plus literal expectations.
module tb_delay_timer_fsm;

  localparam int N  = 3;
  localparam int DW = 4;

  function automatic int cpu_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 1000);
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          start_v   [N];
  logic          data_v    [N];
  logic          ack_v     [N];
  logic          abort_v   [N];
  logic          counting_v[N];
  logic          done_v    [N];
  logic [DW-1:0] count_v   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    delay_timer_fsm #(
      .DELAY_W        (DW),
      .CYCLES_PER_UNIT(cpu_of(g))
    ) u_dut (
      .clk           (clk),
      .reset         (rst),
      .data          (data_v[g]),
      .start_shifting(start_v[g]),
      .ack           (ack_v[g]),
`ifdef TIMER_ABORT_EN
      .abort         (abort_v[g]),
`endif
      .counting      (counting_v[g]),
      .count         (count_v[g]),
      .done          (done_v[g])
    );
  end

  // Timeline model: a run is described by its trigger edge T and delay.
  // Relative to T: bits arrive at T+1..T+DW, counting spans
  // [DW, DW+(delay+1)*C), done from there until ack is seen in DONE.
  int act  [N];
  int trig [N];
  int dly  [N];
  int pq   [N];
  int cntc [N];
  int cyc;
  int checks;
  int errors;

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      act[i] = 0;
      pq[i]  = 0;
    end
  endtask

  task automatic tick();
    logic r;
    logic s_st[N], s_d[N], s_ack[N], s_ab[N];
    @(posedge clk);
    r = rst;
    for (int i = 0; i < N; i++) begin
      s_st[i] = start_v[i]; s_d[i] = data_v[i];
      s_ack[i] = ack_v[i];  s_ab[i] = abort_v[i];
    end
    cyc++;
    if (r) model_reset();
    else begin
      for (int i = 0; i < N; i++) begin
        int rel, fin;
        if (act[i] == 0) begin
          if (s_st[i] && pq[i] == 0) begin
            act[i] = 1; trig[i] = cyc; dly[i] = 0;
          end
        end else begin
          rel = cyc - trig[i];
          fin = DW + (dly[i] + 1) * cpu_of(i);
          if (s_ab[i])                       act[i] = 0;
          else if (rel - 1 >= fin && s_ack[i]) act[i] = 0;
          else if (rel >= 1 && rel <= DW)     dly[i] = dly[i] * 2 + int'(s_d[i]);
        end
        pq[i] = int'(s_st[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      int rel, fin, ec, ecount, ed;
      rel    = cyc - trig[i];
      fin    = DW + (dly[i] + 1) * cpu_of(i);
      ec     = (act[i] != 0 && rel >= DW && rel < fin) ? 1 : 0;
      ecount = (ec != 0) ? dly[i] - (rel - DW) / cpu_of(i) : 0;
      ed     = (act[i] != 0 && rel >= fin) ? 1 : 0;
      chk($sformatf("counting[%0d]@%0d", i, cyc), int'(counting_v[i]), ec);
      chk($sformatf("count[%0d]@%0d", i, cyc), int'(count_v[i]), ecount);
      chk($sformatf("done[%0d]@%0d", i, cyc), int'(done_v[i]), ed);
      if (counting_v[i]) cntc[i]++;
    end
  endtask

  // Trigger, shift d MSB first, wait for done; leaves instance in DONE.
  task automatic run(input int i, input int d, input int ack_mid,
                     input int exp_cyc, input int budget);
    int k;
    cntc[i]    = 0;
    start_v[i] = 1'b1;
    tick();
    for (int b = DW - 1; b >= 0; b--) begin
      data_v[i] = d[b];
      tick();
    end
    data_v[i] = 1'b0;
    chk($sformatf("enter_counting[%0d]", i), int'(counting_v[i]), 1);
    chk($sformatf("enter_count[%0d]", i), int'(count_v[i]), d);
    k = 0;
    while (!done_v[i] && k < budget) begin
      ack_v[i] = (ack_mid != 0 && k >= 5 && k < 50);
      tick();
      k++;
    end
    ack_v[i] = 1'b0;
    chk($sformatf("done_seen[%0d]", i), int'(done_v[i]), 1);
    chk($sformatf("count_cycles[%0d]", i), cntc[i], exp_cyc);
  endtask

  task automatic release_inst(input int i);
    ack_v[i] = 1'b1;
    tick();
    ack_v[i] = 1'b0;
    chk($sformatf("ack_done_low[%0d]", i), int'(done_v[i]), 0);
    start_v[i] = 1'b0;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0;
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      start_v[i] = 1'b0; data_v[i] = 1'b0; ack_v[i] = 1'b0; abort_v[i] = 1'b0;
      trig[i] = 0; dly[i] = 0; cntc[i] = 0;
    end
    model_reset();
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("reset_counting[%0d]", i), int'(counting_v[i]), 0);
      chk($sformatf("reset_count[%0d]", i), int'(count_v[i]), 0);
      chk($sformatf("reset_done[%0d]", i), int'(done_v[i]), 0);
    end
    @(negedge clk);
    repeat (2) tick();
    rst = 1'b0;

    // Delay 5 at 4 cycles/unit: 24 counting cycles, then hold done.
    run(0, 5, 0, 24, 200);
    repeat (10) tick();
    chk("done_hold", int'(done_v[0]), 1);
    ack_v[0] = 1'b1;
    tick();
    ack_v[0] = 1'b0;
    chk("ack_done_low", int'(done_v[0]), 0);
    repeat (5) tick();
    chk("no_retrigger_counting", int'(counting_v[0]), 0);
    chk("no_retrigger_done", int'(done_v[0]), 0);
    start_v[0] = 1'b0;
    tick();

    // Boundary delays at 1 cycle/unit.
    run(1, 0, 0, 1, 50);
    release_inst(1);
    run(1, 15, 0, 16, 100);
    release_inst(1);

    // Asynchronous reset in the middle of COUNT.
    start_v[0] = 1'b1;
    tick();
    for (int b = DW - 1; b >= 0; b--) begin
      data_v[0] = (b < 2);
      tick();
    end
    data_v[0] = 1'b0;
    repeat (3) tick();
    chk("pre_reset_counting", int'(counting_v[0]), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_counting", int'(counting_v[0]), 0);
    chk("async_rst_count", int'(count_v[0]), 0);
    chk("async_rst_done", int'(done_v[0]), 0);
    model_reset();
    start_v[0] = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    run(0, 2, 0, 12, 100);
    release_inst(0);

    // Default unit length, delay 1, with ack pulsed during COUNT.
    run(2, 1, 1, 2000, 2100);
    release_inst(2);

`ifdef TIMER_ABORT_EN
    start_v[0] = 1'b1;
    tick();
    for (int b = DW - 1; b >= 0; b--) begin
      data_v[0] = (b == 0 || b == 2);
      tick();
    end
    data_v[0] = 1'b0;
    repeat (2) tick();
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    chk("abort_counting", int'(counting_v[0]), 0);
    chk("abort_count", int'(count_v[0]), 0);
    chk("abort_done", int'(done_v[0]), 0);
    start_v[0] = 1'b0;
    tick();
    run(0, 0, 0, 4, 50);
    ack_v[0] = 1'b1; abort_v[0] = 1'b1;
    tick();
    ack_v[0] = 1'b0; abort_v[0] = 1'b0;
    chk("abort_ack_done", int'(done_v[0]), 0);
    start_v[0] = 1'b0;
    tick();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/delay_timer_fsm.md
# delay_timer_fsm

Programmable delay timer that sits directly downstream of the start-sequence detector. It consumes the detector's level-high `start_shifting` and shifts a DELAY_W-bit delay value, MSB first, off the same serial `data` line. It then counts (delay+1)×CYCLES_PER_UNIT clock cycles, reporting remaining units on `count`, and raises `done` until the host acknowledges.

## Interface
- CYCLES_PER_UNIT, 1000, clock cycles per delay unit; legal values ≥1.
- DELAY_W, 4, width of the shifted delay value and of `count`.
- clk  input  1  single clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high; forces IDLE immediately.
- data  input  1  serial delay bits, MSB first; same line the upstream detector watches.
- start_shifting  input  1  level from upstream detector; stays high once asserted.
- ack  input  1  host acknowledge of `done`.
- abort  input  1  present only when TIMER_ABORT_EN is defined.
- counting  output  1  high while in COUNT.
- count  output  DELAY_W  remaining whole units in COUNT; 0 in every other state.
- done  output  1  high while in DONE.

## Operation
- The block has four states:
  - IDLE:
    - Go to SHIFT when `start_shifting`=1 and `start_q`=0.
    - `start_q` is the registered previous value of `start_shifting`.
    - This is rising-edge detection, so a level held high by upstream triggers the block only once.
  - SHIFT:
    - Sample `data` into the shift register on each of DELAY_W edges.
    - After the DELAY_W-th sample, go to COUNT.
    - On entry to COUNT, `count` is loaded with the assembled value and the prescaler is cleared.
  - COUNT:
    - The prescaler counts 0..CYCLES_PER_UNIT-1.
    - At prescaler terminal with `count`≠0, decrement `count`.
    - At prescaler terminal with `count`=0, go to DONE.
  - DONE:
    - Hold `done`=1.
    - When `ack`=1 is sampled, go to IDLE.
- Inputs ignored outside their states:
  - `ack` is ignored outside DONE.
  - `start_shifting` edges are ignored outside IDLE; `start_q` still tracks.
- Prescaler width is $clog2(CYCLES_PER_UNIT), with a minimum of 1.
- With CYCLES_PER_UNIT=1, the prescaler is at terminal every cycle.
- `count`=0 after the shift gives exactly CYCLES_PER_UNIT cycles of COUNT.
- `count`=all-ones gives 2^DELAY_W × CYCLES_PER_UNIT cycles of COUNT.

## Timing
- Reset values: state IDLE, `start_q`=0, shift register 0, prescaler 0, `counting`=0, `count`=0, `done`=0.
- Outputs are valid combinationally from registered state with no reset deassertion delay.
- Asserting reset mid-SHIFT or mid-COUNT aborts at once.
- If `start_shifting` is already high when reset releases, it triggers once on the first edge after release.
- With edge E the first edge sampling `start_shifting`=1:
  - E: enter SHIFT.
  - E+1..E+DELAY_W: delay bits sampled, MSB at E+1.
  - E+DELAY_W: enter COUNT, `counting`=1.
  - E+DELAY_W+(delay+1)×CYCLES_PER_UNIT: enter DONE, `counting`=0, `done`=1.
- `done` falls on the first edge sampling `ack`=1.
- If `ack` is already high at DONE entry, DONE lasts exactly one cycle.
- `count` decrements on prescaler terminal edges, so it holds each value for CYCLES_PER_UNIT cycles, except the final 0.

## Configuration
- TIMER_ABORT_EN defined:
  - Port `abort` exists.
  - `abort`=1 sampled in SHIFT, COUNT or DONE returns to IDLE on that edge.
  - Outputs clear on that same edge.
  - `abort` has priority over `ack` and over the prescaler terminal.
- TIMER_ABORT_EN undefined:
  - No `abort` port.
  - Only reset and `ack` leave a non-IDLE state.

## Structure
- Package `delay_timer_pkg` holds:
  - the state enum (IDLE, SHIFT, COUNT, DONE);
  - default DELAY_W and CYCLES_PER_UNIT constants;
  - a prescaler-width function.
- One sub-module, `unit_prescaler`:
  - parameter CYCLES_PER_UNIT;
  - inputs clk, reset, clear, enable;
  - output `tc` (terminal count).
- The FSM, shift register, `start_q` and `count` register live in delay_timer_fsm.

## Test plan
- Delay value, CYCLES_PER_UNIT=4: `start_shifting` rises, then data 0,1,0,1 → `counting` high exactly 24 cycles, `count` steps 5,4,3,2,1,0 every 4 cycles, then `done`=1.
- Done and acknowledge: hold `done` with `ack`=0 for 10 cycles, `done` stays 1; pulse `ack` → `done`=0 next edge and state IDLE. With `start_shifting` still high, no new SHIFT occurs.
- Boundary delays, CYCLES_PER_UNIT=1, DELAY_W=4:
  - Delay 0 → `counting` for exactly 1 cycle.
  - Delay 15 → `counting` for exactly 16 cycles.
- Reset mid-operation: assert reset asynchronously mid-COUNT → `counting`, `count` and `done` go 0 before the next clock edge.
  - Deassert reset, then toggle `start_shifting` low→high → a fresh run completes correctly.
- Default parameters: delay 1 → `done` rises 2000 cycles after COUNT entry; `ack` during COUNT has no effect.
- TIMER_ABORT_EN:
  - `abort` at cycle 3 of COUNT → IDLE with all outputs 0 on that edge.
  - `abort` and `ack` together in DONE → IDLE.
